// File: rtl/fls_ctrl_if.sv
// fls_ctrl_if -- bundles the run request, datapath control and term
// output signals of the sequence controller.
//
// Signals:
//   start, seed0, seed1, count : run request from the requester
//   busy, done, ovf            : run status back to the requester
//   fls_rst, fls_en, fls_d     : control/load towards the sequence datapath
//   fls_f                      : registered datapath output
//   out_valid, out_data        : term offered to the consumer
//   out_ready                  : consumer accepts the offered term
//
// Modports:
//   slave  : the controller (fls_ctrl)
//   master : the environment (requester, datapath and consumer)
interface fls_ctrl_if #(
    parameter int W  = 7,
    parameter int CW = 4
);
    logic          start;
    logic [W-1:0]  seed0;
    logic [W-1:0]  seed1;
    logic [CW-1:0] count;
    logic          busy;
    logic          fls_rst;
    logic          fls_en;
    logic [W-1:0]  fls_d;
    logic [W-1:0]  fls_f;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          done;
    logic          ovf;

    modport slave (
        input  start, seed0, seed1, count, fls_f, out_ready,
        output busy, fls_rst, fls_en, fls_d, out_valid, out_data, done, ovf
    );

    modport master (
        output start, seed0, seed1, count, fls_f, out_ready,
        input  busy, fls_rst, fls_en, fls_d, out_valid, out_data, done, ovf
    );
endinterface

// File: rtl/fls_ctrl.sv
// fls_ctrl -- controller that drives an external Fibonacci-like sequence
// datapath and streams the resulting terms through a valid/ready port.
//
// A run is requested with start; seed0, seed1 and count are latched at that
// moment. The datapath is reset, then stepped once per term: the first two
// steps load the seeds, later steps let the datapath add its last two values.
// Each term is offered on out_data/out_valid until accepted. done pulses for
// one cycle at the end of every run.
//
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : fls_ctrl_if.slave (request, datapath control, term output)
//
// Parameters:
//   W  : width of seeds, datapath and terms
//   CW : width of the term count
//
// Build option:
//   FLS_CTRL_OVF_EN -- when defined, a 3rd-or-later term that is smaller than
//   the previously emitted term is treated as a wrap: the term is not offered,
//   ovf is set (sticky until the next accepted start) and the run ends.
//   When undefined, ovf is tied to 0 and terms wrap modulo 2^W.
module fls_ctrl #(
    parameter int W  = 7,
    parameter int CW = 4
) (
    input  logic      clk,
    input  logic      rst,
    fls_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        RSTDP,
        ISSUE,
        CAP,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  seed0_q, seed0_d;
    logic [W-1:0]  seed1_q, seed1_d;
    logic [CW-1:0] rem_q, rem_d;     // terms still to be emitted
    logic [1:0]    iss_q, iss_d;     // steps issued so far, saturating at 3
    logic          busy_q, busy_d;
    logic          fls_rst_q, fls_rst_d;
    logic          fls_en_q, fls_en_d;
    logic [W-1:0]  fls_d_q, fls_d_d;
    logic          cap_q, cap_d;     // a term is pending in CAP
    logic          done_q, done_d;
    logic          ovf_hit;
    logic          vld;
    logic          hs;
`ifdef FLS_CTRL_OVF_EN
    logic          ovf_q, ovf_d;
    logic [W-1:0]  prev_q, prev_d;   // last term accepted by the consumer
`endif

    // Load value for the next datapath step: seeds on the first two steps,
    // zero afterwards (the datapath ignores fls_d once it is accumulating).
    function automatic logic [W-1:0] issue_data(input logic [1:0] idx,
                                                input logic [W-1:0] s0,
                                                input logic [W-1:0] s1);
        logic [W-1:0] r;
        case (idx)
            2'd0:    r = s0;
            2'd1:    r = s1;
            default: r = '0;
        endcase
        return r;
    endfunction

`ifdef FLS_CTRL_OVF_EN
    // iss_q == 3 in CAP means the pending term is the 3rd or later one.
    assign ovf_hit = cap_q && (iss_q == 2'd3) && (bus.fls_f < prev_q);
`else
    assign ovf_hit = 1'b0;
`endif

    // A wrapped term is never offered, so valid is qualified combinationally
    // with the wrap test on the freshly captured datapath value.
    assign vld = cap_q & ~ovf_hit;
    assign hs  = vld & bus.out_ready;

    always_comb begin
        state_d   = state_q;
        seed0_d   = seed0_q;
        seed1_d   = seed1_q;
        rem_d     = rem_q;
        iss_d     = iss_q;
        busy_d    = busy_q;
        fls_rst_d = 1'b0;
        fls_en_d  = 1'b0;
        fls_d_d   = '0;
        cap_d     = 1'b0;
        done_d    = 1'b0;
`ifdef FLS_CTRL_OVF_EN
        ovf_d     = ovf_q;
        prev_d    = prev_q;
`endif

        // Outputs are registered: each branch sets the values that belong
        // to the state being entered.
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    seed0_d   = bus.seed0;
                    seed1_d   = bus.seed1;
                    rem_d     = bus.count;
                    iss_d     = 2'd0;
                    busy_d    = 1'b1;
`ifdef FLS_CTRL_OVF_EN
                    ovf_d     = 1'b0;
`endif
                    fls_rst_d = 1'b1;
                    state_d   = RSTDP;
                end
            end

            RSTDP: begin
                if (rem_q != '0) begin
                    fls_en_d = 1'b1;
                    fls_d_d  = issue_data(iss_q, seed0_q, seed1_q);
                    state_d  = ISSUE;
                end else begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end

            ISSUE: begin
                iss_d   = (iss_q == 2'd3) ? 2'd3 : iss_q + 2'd1;
                cap_d   = 1'b1;
                state_d = CAP;
            end

            CAP: begin
                if (ovf_hit) begin
`ifdef FLS_CTRL_OVF_EN
                    ovf_d   = 1'b1;
`endif
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else if (hs) begin
                    rem_d  = rem_q - CW'(1);
`ifdef FLS_CTRL_OVF_EN
                    prev_d = bus.fls_f;
`endif
                    if (rem_q == CW'(1)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        fls_en_d = 1'b1;
                        fls_d_d  = issue_data(iss_q, seed0_q, seed1_q);
                        state_d  = ISSUE;
                    end
                end else begin
                    // Stalled: keep offering the same term, datapath frozen.
                    cap_d = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            seed0_q   <= '0;
            seed1_q   <= '0;
            rem_q     <= '0;
            iss_q     <= 2'd0;
            busy_q    <= 1'b0;
            // Hold the datapath in reset while the controller is reset.
            fls_rst_q <= 1'b1;
            fls_en_q  <= 1'b0;
            fls_d_q   <= '0;
            cap_q     <= 1'b0;
            done_q    <= 1'b0;
`ifdef FLS_CTRL_OVF_EN
            ovf_q     <= 1'b0;
            prev_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            seed0_q   <= seed0_d;
            seed1_q   <= seed1_d;
            rem_q     <= rem_d;
            iss_q     <= iss_d;
            busy_q    <= busy_d;
            fls_rst_q <= fls_rst_d;
            fls_en_q  <= fls_en_d;
            fls_d_q   <= fls_d_d;
            cap_q     <= cap_d;
            done_q    <= done_d;
`ifdef FLS_CTRL_OVF_EN
            ovf_q     <= ovf_d;
            prev_q    <= prev_d;
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.fls_rst   = fls_rst_q;
    assign bus.fls_en    = fls_en_q;
    assign bus.fls_d     = fls_d_q;
    assign bus.out_valid = vld;
    // fls_f is frozen while stalled in CAP, so out_data holds steady.
    assign bus.out_data  = vld ? bus.fls_f : '0;
    assign bus.done      = done_q;
`ifdef FLS_CTRL_OVF_EN
    assign bus.ovf       = ovf_q;
`else
    assign bus.ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_fls_ctrl.sv
// tb_fls_ctrl -- directed bench for fls_ctrl with a behavioural datapath,
// a term-list model and a per-cycle compare process.
module tb_fls_ctrl;
    localparam int W  = 7;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fls_ctrl_if #(.W(W), .CW(CW)) bus ();

    fls_ctrl #(.W(W), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Sequence datapath: two loads after fls_rst, then sum of last two.
    logic [W-1:0] dp_f = '0;
    logic [W-1:0] dp_prev = '0;
    int           dp_loads = 0;
    always @(posedge clk) begin
        if (bus.fls_rst) begin
            dp_f     <= '0;
            dp_prev  <= '0;
            dp_loads <= 0;
        end else if (bus.fls_en) begin
            dp_prev <= dp_f;
            if (dp_loads < 2) begin
                dp_f     <= bus.fls_d;
                dp_loads <= dp_loads + 1;
            end else begin
                dp_f <= dp_prev + dp_f;
            end
        end
    end
    assign bus.fls_f = dp_f;

    // Term-list model: the terms a run must emit, and whether it ends in ovf.
    int exp_q[$];
    bit exp_ovf;

    task automatic model_run(input int s0, input int s1, input int n);
        int a, b, t;
        a = 0;
        b = 0;
        exp_q.delete();
        exp_ovf = 0;
        for (int k = 0; k < n; k++) begin
            if (k == 0)      t = s0;
            else if (k == 1) t = s1;
            else             t = (a + b) % (1 << W);
`ifdef FLS_CTRL_OVF_EN
            if (k >= 2 && t < b) begin
                exp_ovf = 1;
                break;
            end
`endif
            exp_q.push_back(t);
            a = b;
            b = t;
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Compare process: scoreboard on handshakes plus per-cycle invariants.
    int           hs_cnt = 0;
    int           done_cnt = 0;
    int           done_cyc = -1;
    int           first_vld_cyc = -1;
    logic         stall_prev = 1'b0;
    logic [W-1:0] data_prev = '0;
    int           e;

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (int'(bus.out_valid) + int'(bus.fls_en) + int'(bus.fls_rst) > 1) begin
                errors++;
                $display("FAIL excl: valid=%0b en=%0b rst=%0b required at most one high",
                         bus.out_valid, bus.fls_en, bus.fls_rst);
            end
            if (stall_prev) begin
                checks++;
                if (!bus.out_valid || bus.out_data !== data_prev || bus.fls_en) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%0b data=%0d en=%0b required 1,%0d,0",
                             bus.out_valid, bus.out_data, bus.fls_en, data_prev);
                end
            end
            if (bus.out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL term_unexpected: got %0d expected no term", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(bus.out_data) != e) begin
                        errors++;
                        $display("FAIL term: got %0d expected %0d", bus.out_data, e);
                    end
                end
                hs_cnt++;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                checks++;
                if (bus.busy) begin
                    errors++;
                    $display("FAIL done_busy: busy=%0b expected 0", bus.busy);
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            data_prev  = bus.out_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    int start_cyc;
    int done_base;

    task automatic launch(input int s0, input int s1, input int n);
        model_run(s0, s1, n);
        first_vld_cyc = -1;
        done_base     = done_cnt;
        @(posedge clk); #1;
        bus.seed0 = W'(s0);
        bus.seed1 = W'(s1);
        bus.count = CW'(n);
        bus.start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (done_cnt != done_base) break;
        end
        check({name, "_done_seen"}, done_cnt - done_base, 1);
        repeat (3) @(negedge clk);
        #1;
        check({name, "_done_single"}, done_cnt - done_base, 1);
        check({name, "_leftover"}, exp_q.size(), 0);
        check({name, "_busy_end"}, int'(bus.busy), 0);
        check({name, "_ovf"}, int'(bus.ovf), int'(exp_ovf));
    endtask

    task automatic wait_hs(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (hs_cnt >= target) break;
            @(negedge clk); #1;
        end
        check("hs_wait", int'(hs_cnt >= target), 1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"},      int'(bus.busy), 0);
        check({name, "_fls_en"},    int'(bus.fls_en), 0);
        check({name, "_fls_d"},     int'(bus.fls_d), 0);
        check({name, "_out_valid"}, int'(bus.out_valid), 0);
        check({name, "_out_data"},  int'(bus.out_data), 0);
        check({name, "_done"},      int'(bus.done), 0);
        check({name, "_ovf"},       int'(bus.ovf), 0);
        check({name, "_fls_rst"},   int'(bus.fls_rst), 1);
    endtask

    initial begin
        int lit_basic[5];
        int lit_ovf[$];
        int base;
        bit seen;

        bus.start     = 1'b0;
        bus.seed0     = '0;
        bus.seed1     = '0;
        bus.count     = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        rst = 1'b0;

        // Model pins against hand-computed sequences
        lit_basic = '{2, 3, 5, 8, 13};
        model_run(2, 3, 5);
        check("pin_basic_len", exp_q.size(), 5);
        for (int i = 0; i < 5; i++) check("pin_basic", exp_q[i], lit_basic[i]);
`ifdef FLS_CTRL_OVF_EN
        lit_ovf = '{64, 64};
`else
        lit_ovf = '{64, 64, 0, 64};
`endif
        model_run(64, 64, 4);
        check("pin_ovf_len", exp_q.size(), lit_ovf.size());
        for (int i = 0; i < lit_ovf.size(); i++) check("pin_ovf", exp_q[i], lit_ovf[i]);
        exp_q.delete();

        // Basic run, with a start pulse mid-run that must be ignored
        launch(2, 3, 5);
        repeat (3) @(posedge clk);
        #1;
        bus.seed0 = 7'd9; bus.seed1 = 7'd9; bus.count = 4'd1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done("basic", 60);
        check("basic_first_latency", first_vld_cyc - start_cyc, 3);
        check("basic_done_latency", done_cyc - start_cyc, 12);

        // Backpressure at term 3
        launch(2, 3, 5);
        wait_hs(hs_cnt + 2, 60);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("bp_valid", int'(bus.out_valid), 1);
        check("bp_data", int'(bus.out_data), 5);
        check("bp_en", int'(bus.fls_en), 0);
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_done("bp", 60);

        // Zero count; start held into the busy cycle with a nonzero count
        model_run(0, 0, 0);
        first_vld_cyc = -1;
        done_base     = done_cnt;
        @(posedge clk); #1;
        bus.seed0 = 7'd1; bus.seed1 = 7'd1; bus.count = 4'd0; bus.start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        check("zero_busy", int'(bus.busy), 1);
        bus.seed0 = 7'd7; bus.seed1 = 7'd7; bus.count = 4'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done("zero", 20);
        check("zero_done_latency", done_cyc - start_cyc, 2);
        repeat (6) @(negedge clk);
        #1;
        check("zero_no_valid", first_vld_cyc, -1);

        // Overflow / wrap
        launch(64, 64, 4);
        wait_done("ovf", 60);
`ifdef FLS_CTRL_OVF_EN
        check("ovf_flag", int'(bus.ovf), 1);
`else
        check("ovf_flag", int'(bus.ovf), 0);
`endif

        // Reset during CAP of term 2
        launch(2, 3, 5);
        base = hs_cnt;
        wait_hs(base + 1, 40);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (bus.out_valid) begin
                seen = 1;
                break;
            end
        end
        check("midrst_cap_reached", int'(seen), 1);
        check("midrst_term2", int'(bus.out_data), 3);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        rst = 1'b0;
        exp_q.delete();
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_idle_busy", int'(bus.busy), 0);
        check("midrst_idle_valid", int'(bus.out_valid), 0);
        launch(2, 3, 3);
        wait_done("after_rst", 40);
        check("after_rst_latency", first_vld_cyc - start_cyc, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
